// File: rtl/ascon_pack.sv
// Shared ASCON types, constants and helper functions for the permutation engine.
// The 320-bit state is five 64-bit words; word i is ASCON's x_i.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam int PA_ROUNDS_DEF = 12;
    localparam int PB_ROUNDS_DEF = 6;
    localparam int NUM_ROUNDS    = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } perm_fsm_t;

    // Column S-box, input {x0,x1,x2,x3,x4} with x0 as the MSB.
    localparam logic [4:0] SBOX_LUT [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [4:0] sbox(input logic [4:0] x);
        return SBOX_LUT[x];
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, substitution layer, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state added;
    type_state subst;

    always_comb begin
        added          = state_i;
        added[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
    end

    always_comb begin
        subst = '0;
        for (int j = 0; j < 64; j++) begin
            {subst[0][j], subst[1][j], subst[2][j], subst[3][j], subst[4][j]} =
                sbox({added[0][j], added[1][j], added[2][j], added[3][j], added[4][j]});
        end
    end

    always_comb begin
        state_o = '0;
        for (int i = 0; i < 5; i++) begin
            state_o[i] = subst[i] ^ ror64(subst[i], ROT_A[i]) ^ ror64(subst[i], ROT_B[i]);
        end
    end

endmodule

// File: rtl/ascon_permutation_iter.sv
// Iterative ASCON p^a / p^b engine: UNROLL rounds per clock on an internal state register,
// with a start/busy/done handshake.
module ascon_permutation_iter
    import ascon_pack::*;
#(
    parameter int PA_ROUNDS = PA_ROUNDS_DEF,
    parameter int PB_ROUNDS = PB_ROUNDS_DEF,
    parameter int UNROLL    = 1
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);

    if (PA_ROUNDS < 1 || PA_ROUNDS > NUM_ROUNDS || PB_ROUNDS < 1 || PB_ROUNDS > NUM_ROUNDS ||
        UNROLL < 1 || (PA_ROUNDS % UNROLL) != 0 || (PB_ROUNDS % UNROLL) != 0) begin : g_param_error
        $error("ascon_permutation_iter: illegal PA_ROUNDS/PB_ROUNDS/UNROLL combination");
    end

    localparam logic [3:0] PA_START = 4'(NUM_ROUNDS - PA_ROUNDS);
    localparam logic [3:0] PB_START = 4'(NUM_ROUNDS - PB_ROUNDS);
    localparam logic [3:0] STEP     = 4'(UNROLL);
    localparam logic [3:0] LAST     = 4'(NUM_ROUNDS);

    perm_fsm_t  fsm_q, fsm_d;
    logic [3:0] round_q, round_d;
    type_state  state_q, state_d;
    type_state  chain [UNROLL+1];
    logic [3:0] round_step;

    assign chain[0]   = state_q;
    assign round_step = round_q + STEP;

    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        ascon_round u_round (
            .state_i (chain[u]),
            .round_i (round_q + 4'(u)),
            .state_o (chain[u+1])
        );
    end

    // NOTE: the full state register is reset because an aborted run must not leak a partial result.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            ST_IDLE: if (start_i) fsm_d = ST_RUN;
            ST_RUN:  if (round_step == LAST) fsm_d = ST_DONE;
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    // NOTE: hold-by-default assignments keep this block free of inferred latches.
    always_comb begin
        round_d = round_q;
        state_d = state_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = state_i;
                    round_d = mode_i ? PB_START : PA_START;
                end
            end
            ST_RUN: begin
                state_d = chain[UNROLL];
                round_d = round_step;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o  = (fsm_q == ST_RUN);
        done_o  = (fsm_q == ST_DONE);
        round_o = round_q;
        state_o = state_q;
    end

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Scoreboard bench: UNROLL=1 and UNROLL=3 engines driven in parallel, checked against a
// bit-sliced ASCON model and a cycle-level handshake model.
module tb_ascon_permutation_iter;
    import ascon_pack::*;

    typedef struct {
        type_state result;
        time       done_t;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b1;
    logic      start = 1'b0;
    logic      mode = 1'b0;
    type_state state_in = '0;

    int checks = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [319:0] actual, input logic [319:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        type_state   o;
        c  = 8'((15 - r) * 16 + r);
        x0 = s[0]; x1 = s[1]; x2 = s[2] ^ {56'd0, c}; x3 = s[3]; x4 = s[4];
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        o[0] = x0 ^ rr(x0, 19) ^ rr(x0, 28);
        o[1] = x1 ^ rr(x1, 61) ^ rr(x1, 39);
        o[2] = x2 ^ rr(x2, 1)  ^ rr(x2, 6);
        o[3] = x3 ^ rr(x3, 10) ^ rr(x3, 17);
        o[4] = x4 ^ rr(x4, 7)  ^ rr(x4, 41);
        return o;
    endfunction

    function automatic type_state model_perm(input type_state s, input int rounds);
        type_state t = s;
        for (int r = 12 - rounds; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int U = (g == 0) ? 1 : 3;

        type_state  st_o;
        logic       busy;
        logic       done;
        logic [3:0] rnd;

        exp_t       exp_q [$];
        int         blocked = 0;
        logic [3:0] exp_round = '0;

        ascon_permutation_iter #(
            .PA_ROUNDS (12),
            .PB_ROUNDS (6),
            .UNROLL    (U)
        ) u_dut (
            .clock_i  (clk),
            .resetb_i (rst_n),
            .start_i  (start),
            .mode_i   (mode),
            .state_i  (state_in),
            .state_o  (st_o),
            .busy_o   (busy),
            .done_o   (done),
            .round_o  (rnd)
        );

        // Handshake model: decides acceptance and pushes the expected result.
        initial begin
            int r_cnt;
            int n;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    blocked   = 0;
                    exp_round = '0;
                end else if (blocked > 0) begin
                    if (blocked >= 2) exp_round = exp_round + 4'(U);
                    blocked--;
                end else if (start) begin
                    r_cnt     = mode ? 6 : 12;
                    n         = r_cnt / U;
                    blocked   = n + 1;
                    exp_round = 4'(12 - r_cnt);
                    exp_q.push_back('{result: model_perm(state_in, r_cnt),
                                      done_t: $time + time'(10 * n + 5)});
                end
            end
        end

        // Monitor: compares outputs every cycle and pops the scoreboard on done.
        initial begin
            type_state held = '0;
            exp_t      e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    held = '0;
                    exp_q.delete();
                end
                check($sformatf("u%0d_busy", U), busy, (blocked >= 2));
                check($sformatf("u%0d_done", U), done, (blocked == 1));
                check($sformatf("u%0d_round", U), rnd, exp_round);
                if (blocked == 0) check($sformatf("u%0d_state_held", U), st_o, held);
                if (done && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("u%0d_result", U), st_o, e.result);
                    check($sformatf("u%0d_done_time", U), 320'($time), 320'(e.done_t));
                    held = e.result;
                end
            end
        end
    end

    task automatic issue(input logic m, input type_state s);
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        state_in = s;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((g_inst[0].exp_q.size() != 0 || g_inst[1].exp_q.size() != 0 ||
                g_inst[0].blocked != 0 || g_inst[1].blocked != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_budget", 320'(n >= budget), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_u1_state"}, g_inst[0].st_o, '0);
        check({tag, "_u1_busy"},  g_inst[0].busy, '0);
        check({tag, "_u1_done"},  g_inst[0].done, '0);
        check({tag, "_u1_round"}, g_inst[0].rnd,  '0);
        check({tag, "_u3_state"}, g_inst[1].st_o, '0);
        check({tag, "_u3_busy"},  g_inst[1].busy, '0);
        check({tag, "_u3_done"},  g_inst[1].done, '0);
        check({tag, "_u3_round"}, g_inst[1].rnd,  '0);
    endtask

    initial begin
        type_state zero_s;
        type_state vec_s;
        zero_s   = '0;
        vec_s[0] = 64'h80400c0600000000;
        vec_s[1] = 64'h8a55114d1cb6a9a2;
        vec_s[2] = 64'hbe263d4d7aecaa0f;
        vec_s[3] = 64'h4ed0ec0b98c529b7;
        vec_s[4] = 64'hc8cddf37bcd0284a;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #2 rst_n = 1'b1;

        issue(1'b0, zero_s);
        drain(40);
        issue(1'b1, vec_s);
        drain(40);
        issue(1'b0, vec_s);
        drain(40);
        issue(1'b1, zero_s);
        drain(40);

        // Abort a p^a run part-way through with an asynchronous mid-cycle reset.
        issue(1'b0, vec_s);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (16) @(negedge clk);
        issue(1'b1, vec_s);
        drain(40);

        // start held high while mode and state churn every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            mode = ~mode;
            for (int w = 0; w < 5; w++) state_in[w] = {$urandom, $urandom};
            @(negedge clk);
        end
        start = 1'b0;
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_permutation_iter.md
Name: ascon_permutation_iter

Overview:
Iterative, parametrised ASCON permutation engine applying p^a or p^b to a 320-bit state held in an internal register. Each clock edge applies UNROLL rounds, each made of constant addition, substitution layer and linear diffusion. Round count and unroll factor are parameters, and a start/busy/done handshake is provided. The block sits between the mode FSM (init, associated data, plaintext, finalisation) and the state register, replacing one-round-per-call usage of the round primitives.

Parameters:
PA_ROUNDS, 12, rounds for mode_i=0 (p^a); legal 1..12
PB_ROUNDS, 6, rounds for mode_i=1 (p^b); legal 1..12
UNROLL, 1, rounds computed per clock; must divide both PA_ROUNDS and PB_ROUNDS; elaboration error otherwise

Ports:
clock_i  in  1  system clock, rising edge
resetb_i  in  1  reset, asynchronous, active-low
start_i  in  1  request; sampled only when idle
mode_i  in  1  0 = p^a, 1 = p^b; sampled with start_i
state_i  in  type_state (5x64)  input state; sampled with start_i
state_o  out  type_state  permutation result; held after done
busy_o  out  1  high while rounds are in progress
done_o  out  1  one-cycle pulse when state_o is valid
round_o  out  4  round index r of the next round to apply (debug)

Behaviour:
- Reset (resetb_i=0, async): FSM to IDLE; state register all-zero; state_o=0; busy_o=0; done_o=0; round_o=0. Reset mid-run aborts with no done_o, and the state register is cleared.
- Round indexing follows the ASCON spec: for R rounds, r runs from 12-R to 11. Constant c_r = {(4'hF - r), r[3:0]} is XORed into bits 7:0 of state[2] (r=0 -> 0xF0, r=6 -> 0x96, r=11 -> 0x4B).
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start_i=1, load state_i into the register, set round counter to 12-R (R selected by mode_i), latch the mode, and go to RUN. busy_o is high from the following cycle.
- RUN: each edge applies UNROLL consecutive rounds r..r+UNROLL-1 to the register and advances the counter by UNROLL. When the counter reaches 12, go to DONE. RUN lasts R/UNROLL edges.
- DONE: done_o=1 and busy_o=0 for exactly one cycle, then return to IDLE. state_o = register contents, held stable until the next accepted start.
- Latency: start edge k gives done_o high during the cycle after edge k+R/UNROLL. Example: p^a with UNROLL=1 puts done_o in the cycle after edge k+12.
- Back-to-back operation: start_i high while done_o is high is ignored. start_i is accepted again in IDLE, so the minimum issue interval is R/UNROLL+2 cycles.
- start_i while busy: ignored. mode_i and state_i changes during RUN have no effect.
- Counter is 4-bit and never wraps; it saturates at 12 on exit from RUN. round_o=12 in DONE, then holds its value in IDLE.
- Substitution layer uses the standard 5-bit ASCON S-box per column (bit j of state[0..4] forms input x0..x4).
- Linear layer rotation pairs: state[0] (19,28), state[1] (61,39), state[2] (1,6), state[3] (10,17), state[4] (7,41).

Decomposition:
- ascon_pack gains: type_state (already present), constants PA_ROUNDS_DEF=12 and PB_ROUNDS_DEF=6, a function round_const(r) returning the 8-bit c_r, the S-box lookup table, and the rotation amounts.
- Sub-module ascon_round: purely combinational, state_i plus round_i -> state_o. It chains the existing constant_addition with the substitution layer and the linear diffusion layer.
- ascon_permutation_iter instantiates UNROLL copies of ascon_round in a generate chain feeding the state register, plus the FSM and counter.

Test Plan:
- Reset: resetb_i low asynchronously mid-cycle during RUN -> busy_o, done_o and round_o drop to 0 and state_o=0 immediately. No done_o after release; new start works normally.
- p^a, UNROLL=1, all-zero state, start at edge 0:
  - round_o steps 0,1,...,11 on edges 1..12.
  - done_o is high only in the cycle after edge 12.
  - state_o equals the golden C-model p^12 of the zero state.
  - busy_o is high for 12 cycles.
- p^b, PB_ROUNDS=6: state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}.
  - First round_o value is 6 (constant 0x96); done_o arrives after 6 RUN edges.
  - state_o matches the golden p^6 result.
- UNROLL=3 with PA_ROUNDS=12 and PB_ROUNDS=6 on the same vectors -> identical state_o to UNROLL=1; done_o after 4 and 2 RUN edges respectively.
- start_i held high continuously with random state_i and mode_i toggling during RUN -> only the start sampled in IDLE is used. Result matches the input captured at acceptance; issue interval is exactly R/UNROLL+2 cycles.
- Elaboration with UNROLL=5 and PA_ROUNDS=12 -> elaboration error raised.
